// File: rtl/sc_match_scorer_if.sv
// rtl/sc_match_scorer_if.sv - match-event bus between note matcher, scorer and score display
//
// Purpose: bundles the matcher-side inputs (pause, song time, match/miss pulses
// and captured note times) and the scorer outputs (serialised event, grade,
// score, combo, overflow) into one parametrised interface.
//
// Signals:
//   pause          : game paused, stalls arbitration
//   song_time      : current song time (ms ticks)
//   match_trigger  : one-cycle match pulse per channel
//   match_time     : note time for channel i at [i*TIME_W +: TIME_W]
//   miss_trigger   : one-cycle missed-note pulse per channel
//   match_en       : serialised event valid (one cycle)
//   match_ch       : channel of the event
//   match_dt       : song_time - captured time at grant
//   hit_grade      : grade of the last scored event (0..3)
//   score          : saturating accumulated score
//   combo          : current combo count
//   overflow       : sticky, a trigger hit an already-pending channel
//
// Modports: master drives the inputs (matcher side), slave is the scorer.
interface sc_match_scorer_if #(
  parameter int NUM_CH  = 37,
  parameter int TIME_W  = 16,
  parameter int SCORE_W = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     pause;
  logic [TIME_W-1:0]        song_time;
  logic [NUM_CH-1:0]        match_trigger;
  logic [NUM_CH*TIME_W-1:0] match_time;
  logic [NUM_CH-1:0]        miss_trigger;

  logic                     match_en;
  logic [CH_W-1:0]          match_ch;
  logic [TIME_W-1:0]        match_dt;
  logic [1:0]               hit_grade;
  logic [SCORE_W-1:0]       score;
  logic [15:0]              combo;
  logic                     overflow;

  modport master (
    output pause, song_time, match_trigger, match_time, miss_trigger,
    input  match_en, match_ch, match_dt, hit_grade, score, combo, overflow
  );

  modport slave (
    input  pause, song_time, match_trigger, match_time, miss_trigger,
    output match_en, match_ch, match_dt, hit_grade, score, combo, overflow
  );
endinterface

// File: rtl/sc_match_scorer.sv
// rtl/sc_match_scorer.sv - per-channel match capture, round-robin serialiser and score grader
//
// Purpose: captures per-channel match pulses into pending slots, serialises
// them with a round-robin arbiter into one (channel, dt) event stream, grades
// each event against timing windows and accumulates a saturating score.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : sc_match_scorer_if.slave (see interface file for signal list)
//
// Pipeline: grant in cycle N (pending bit clears at the N edge), event on
// match_en in N+1, grade/score/combo update in N+2.
//
// Optional feature: define SC_COMBO_EN to enable the combo counter and score
// multiplier; without it combo is 0, mult is 1 and miss_trigger is ignored.
module sc_match_scorer #(
  parameter int NUM_CH      = 37,
  parameter int TIME_W      = 16,
  parameter int SCORE_W     = 32,
  parameter int WIN_PERFECT = 50,
  parameter int WIN_GOOD    = 150,
  parameter int WIN_OK      = 300,
  parameter int PTS_PERFECT = 100,
  parameter int PTS_GOOD    = 50,
  parameter int PTS_OK      = 10
) (
  input  logic              clk,
  input  logic              reset,
  sc_match_scorer_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Headroom so points x mult plus the score never wraps before saturation.
  localparam int AW   = SCORE_W + 16;

  // Pending slots
  logic [NUM_CH-1:0] pend_v_q, pend_v_d;
  logic [TIME_W-1:0] pend_t_q [NUM_CH];
  logic [TIME_W-1:0] pend_t_d [NUM_CH];
  logic              ovf_q, ovf_d;

  // Arbiter
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              gnt_v;
  logic [CH_W-1:0]   gnt_ch;

  // Event stage (N+1)
  logic              ev_v_q, ev_v_d;
  logic [CH_W-1:0]   ev_ch_q, ev_ch_d;
  logic [TIME_W-1:0] ev_dt_q, ev_dt_d;

  // Score stage (N+2)
  logic [1:0]        grade_q, grade_d;
  logic [1:0]        grade_c;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [15:0]       combo_q, combo_d;
  logic [2:0]        mult_c;
  logic [AW-1:0]     pts_c;
  logic [AW-1:0]     sum_c;

  // Round-robin search starting at ptr, wrapping modulo NUM_CH.
  always_comb begin
    int            idx;
    logic [CH_W-1:0] idx_c;
    gnt_v  = 1'b0;
    gnt_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_c = CH_W'(idx);
      if (!gnt_v && pend_v_q[idx_c]) begin
        gnt_v  = 1'b1;
        gnt_ch = idx_c;
      end
    end
    if (bus.pause) begin
      gnt_v  = 1'b0;
      gnt_ch = '0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_v) begin
      if (gnt_ch == CH_W'(NUM_CH - 1)) ptr_d = '0;
      else                             ptr_d = gnt_ch + 1'b1;
    end
  end

  // Slot update: a trigger on a slot being granted this cycle reloads it,
  // otherwise a trigger on a pending slot is dropped and flagged.
  always_comb begin
    logic granted;
    pend_v_d = pend_v_q;
    ovf_d    = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pend_t_d[i] = pend_t_q[i];
      granted     = gnt_v && (gnt_ch == CH_W'(i));
      if (bus.match_trigger[i]) begin
        if (pend_v_q[i] && !granted) begin
          ovf_d = 1'b1;
        end else begin
          pend_v_d[i] = 1'b1;
          pend_t_d[i] = bus.match_time[i*TIME_W +: TIME_W];
        end
      end else if (granted) begin
        pend_v_d[i] = 1'b0;
      end
    end
  end

  // Event stage: dt is taken modulo 2^TIME_W against the old captured time.
  always_comb begin
    ev_v_d  = gnt_v;
    ev_ch_d = ev_ch_q;
    ev_dt_d = ev_dt_q;
    if (gnt_v) begin
      ev_ch_d = gnt_ch;
      ev_dt_d = bus.song_time - pend_t_q[gnt_ch];
    end
  end

  // Grading
  always_comb begin
    grade_c = 2'd0;
    pts_c   = '0;
    if (ev_dt_q <= TIME_W'(WIN_PERFECT)) begin
      grade_c = 2'd3;
      pts_c   = AW'(PTS_PERFECT);
    end else if (ev_dt_q <= TIME_W'(WIN_GOOD)) begin
      grade_c = 2'd2;
      pts_c   = AW'(PTS_GOOD);
    end else if (ev_dt_q <= TIME_W'(WIN_OK)) begin
      grade_c = 2'd1;
      pts_c   = AW'(PTS_OK);
    end
  end

`ifdef SC_COMBO_EN
  // mult uses the combo value from before this event's update.
  always_comb begin
    logic [15:0] combo_div;
    combo_div = combo_q / 16'd10;
    if (combo_div >= 16'd3) mult_c = 3'd4;
    else                    mult_c = 3'(combo_div) + 3'd1;
  end

  always_comb begin
    combo_d = combo_q;
    if (ev_v_q) begin
      if (grade_c != 2'd0) begin
        if (combo_q != 16'hFFFF) combo_d = combo_q + 16'd1;
      end else begin
        combo_d = '0;
      end
    end
    // A miss in the same cycle as a hit wins over the increment.
    if (|bus.miss_trigger) combo_d = '0;
  end
`else
  always_comb begin
    mult_c  = 3'd1;
    combo_d = '0;
  end
`endif

  always_comb begin
    grade_d = grade_q;
    score_d = score_q;
    sum_c   = AW'(score_q) + pts_c * AW'(mult_c);
    if (ev_v_q) begin
      grade_d = grade_c;
      if (|sum_c[AW-1:SCORE_W]) score_d = '1;
      else                      score_d = sum_c[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v_q <= '0;
      for (int i = 0; i < NUM_CH; i++) pend_t_q[i] <= '0;
      ovf_q    <= 1'b0;
      ptr_q    <= '0;
      ev_v_q   <= 1'b0;
      ev_ch_q  <= '0;
      ev_dt_q  <= '0;
      grade_q  <= '0;
      score_q  <= '0;
      combo_q  <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      for (int i = 0; i < NUM_CH; i++) pend_t_q[i] <= pend_t_d[i];
      ovf_q    <= ovf_d;
      ptr_q    <= ptr_d;
      ev_v_q   <= ev_v_d;
      ev_ch_q  <= ev_ch_d;
      ev_dt_q  <= ev_dt_d;
      grade_q  <= grade_d;
      score_q  <= score_d;
      combo_q  <= combo_d;
    end
  end

  assign bus.match_en  = ev_v_q;
  assign bus.match_ch  = ev_ch_q;
  assign bus.match_dt  = ev_dt_q;
  assign bus.hit_grade = grade_q;
  assign bus.score     = score_q;
  assign bus.combo     = combo_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_sc_match_scorer.sv
// tb/tb_sc_match_scorer.sv - directed self-checking bench for sc_match_scorer
module tb_sc_match_scorer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sc_match_scorer_if #(.NUM_CH(37), .TIME_W(16), .SCORE_W(32)) bus ();
  sc_match_scorer_if #(.NUM_CH(37), .TIME_W(16), .SCORE_W(8))  bus2 ();

  assign bus2.pause         = bus.pause;
  assign bus2.song_time     = bus.song_time;
  assign bus2.match_trigger = bus.match_trigger;
  assign bus2.match_time    = bus.match_time;
  assign bus2.miss_trigger  = bus.miss_trigger;

  sc_match_scorer #(.NUM_CH(37), .TIME_W(16), .SCORE_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sc_match_scorer #(.NUM_CH(37), .TIME_W(16), .SCORE_W(8)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_ch[$];
  int ev_dt[$];
  int ev_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && bus.match_en) begin
      ev_ch.push_back(int'(bus.match_ch));
      ev_dt.push_back(int'(bus.match_dt));
      ev_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    ev_ch.delete();
    ev_dt.delete();
    ev_cyc.delete();
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus.pause         = 1'b0;
    bus.match_trigger = '0;
    bus.miss_trigger  = '0;
    tick();
    tick();
    reset = 1'b0;
    clear_events();
  endtask

  task automatic set_trig(input int ch, input logic [15:0] t);
    bus.match_trigger[ch]       = 1'b1;
    bus.match_time[ch*16 +: 16] = t;
  endtask

  task automatic pulse_done();
    tick();
    bus.match_trigger = '0;
  endtask

  task automatic wait_events(input int n);
    int budget;
    budget = 200;
    while (ev_ch.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    tick();
    check_eq("drain_count", 64'(ev_ch.size()), 64'(n));
  endtask

  typedef struct {
    logic [15:0] t;
    logic [15:0] song;
    int          grade;
    int          score;
    int          score8;
  } win_vec_t;

  win_vec_t win_tab[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.song_time  = '0;
    bus.match_time = '0;
    do_reset();

    // Reset state
    check_eq("rst_match_en", 64'(bus.match_en), 0);
    check_eq("rst_match_ch", 64'(bus.match_ch), 0);
    check_eq("rst_match_dt", 64'(bus.match_dt), 0);
    check_eq("rst_grade",    64'(bus.hit_grade), 0);
    check_eq("rst_score",    64'(bus.score), 0);
    check_eq("rst_combo",    64'(bus.combo), 0);
    check_eq("rst_overflow", 64'(bus.overflow), 0);

    // Single trigger with exact latency
    bus.song_time = 16'd1030;
    set_trig(5, 16'd1000);
    pulse_done();
    check_eq("single_grant_cycle_en", 64'(bus.match_en), 0);
    tick();
    check_eq("single_en",    64'(bus.match_en), 1);
    check_eq("single_ch",    64'(bus.match_ch), 5);
    check_eq("single_dt",    64'(bus.match_dt), 30);
    check_eq("single_score_early", 64'(bus.score), 0);
    tick();
    check_eq("single_en_off", 64'(bus.match_en), 0);
    check_eq("single_grade", 64'(bus.hit_grade), 3);
    check_eq("single_score", 64'(bus.score), 100);

    // Reset mid-flight discards the event
    do_reset();
    set_trig(5, 16'd1000);
    pulse_done();
    tick();
    check_eq("flush_en_before", 64'(bus.match_en), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check_eq("flush_score", 64'(bus.score), 0);
    check_eq("flush_grade", 64'(bus.hit_grade), 0);
    check_eq("flush_en",    64'(bus.match_en), 0);

    // Simultaneous triggers drain in order with wrap
    do_reset();
    bus.song_time = 16'd500;
    set_trig(0, 16'd490);
    set_trig(3, 16'd490);
    set_trig(36, 16'd490);
    pulse_done();
    wait_events(3);
    if (ev_ch.size() == 3) begin
      check_eq("rr_ord0", 64'(ev_ch[0]), 0);
      check_eq("rr_ord1", 64'(ev_ch[1]), 3);
      check_eq("rr_ord2", 64'(ev_ch[2]), 36);
      check_eq("rr_back2back0", 64'(ev_cyc[1] - ev_cyc[0]), 1);
      check_eq("rr_back2back1", 64'(ev_cyc[2] - ev_cyc[1]), 1);
    end
    check_eq("rr_score", 64'(bus.score), 300);
    clear_events();
    set_trig(1, 16'd490);
    set_trig(0, 16'd490);
    pulse_done();
    wait_events(2);
    if (ev_ch.size() == 2) begin
      check_eq("rr_wrap_first",  64'(ev_ch[0]), 0);
      check_eq("rr_wrap_second", 64'(ev_ch[1]), 1);
    end
    check_eq("rr_score2", 64'(bus.score), 500);

    // Re-trigger while pending: dropped, sticky overflow
    do_reset();
    bus.song_time = 16'd2000;
    bus.pause = 1'b1;
    set_trig(2, 16'd1900);
    pulse_done();
    tick();
    set_trig(2, 16'd1950);
    pulse_done();
    check_eq("ovf_set", 64'(bus.overflow), 1);
    bus.pause = 1'b0;
    wait_events(1);
    tick();
    tick();
    check_eq("ovf_single_event", 64'(ev_ch.size()), 1);
    if (ev_dt.size() > 0) check_eq("ovf_old_time_kept", 64'(ev_dt[0]), 100);
    check_eq("ovf_sticky", 64'(bus.overflow), 1);
    check_eq("ovf_grade", 64'(bus.hit_grade), 2);

    // Re-trigger in own grant cycle: reload, no overflow
    do_reset();
    check_eq("ovf_reset_clear", 64'(bus.overflow), 0);
    set_trig(2, 16'd1900);
    pulse_done();
    set_trig(2, 16'd1980);
    pulse_done();
    wait_events(2);
    if (ev_dt.size() == 2) begin
      check_eq("reload_dt0", 64'(ev_dt[0]), 100);
      check_eq("reload_dt1", 64'(ev_dt[1]), 20);
    end
    check_eq("reload_no_ovf", 64'(bus.overflow), 0);

    // Window boundaries, wrap and saturation (8-bit score on dut_sat)
    win_tab[0] = '{16'd850,   16'd1000,   2,  50,  50};
    win_tab[1] = '{16'd699,   16'd1000,   0,  50,  50};
    win_tab[2] = '{16'hFFF0,  16'h0010,   3, 150, 150};
    win_tab[3] = '{16'd950,   16'd1000,   3, 250, 250};
    win_tab[4] = '{16'd949,   16'd1000,   2, 300, 255};
    win_tab[5] = '{16'd700,   16'd1000,   1, 310, 255};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.song_time = win_tab[k].song;
      set_trig(7, win_tab[k].t);
      pulse_done();
      repeat (4) tick();
      check_eq($sformatf("win%0d_grade", k),  64'(bus.hit_grade), 64'(win_tab[k].grade));
      check_eq($sformatf("win%0d_score", k),  64'(bus.score),     64'(win_tab[k].score));
      check_eq($sformatf("win%0d_score8", k), 64'(bus2.score),    64'(win_tab[k].score8));
    end
    check_eq("wrap_dt", 64'(ev_dt[2]), 32);

    // Pause holds slots and grants
    do_reset();
    bus.song_time = 16'd3000;
    bus.pause = 1'b1;
    set_trig(10, 16'd2990);
    set_trig(20, 16'd2980);
    set_trig(30, 16'd2970);
    set_trig(4,  16'd2960);
    pulse_done();
    repeat (20) tick();
    check_eq("pause_no_events", 64'(ev_ch.size()), 0);
    bus.pause = 1'b0;
    wait_events(4);
    if (ev_ch.size() == 4) begin
      check_eq("pause_ch0", 64'(ev_ch[0]), 4);
      check_eq("pause_ch1", 64'(ev_ch[1]), 10);
      check_eq("pause_ch2", 64'(ev_ch[2]), 20);
      check_eq("pause_ch3", 64'(ev_ch[3]), 30);
      check_eq("pause_dt0", 64'(ev_dt[0]), 40);
      check_eq("pause_dt3", 64'(ev_dt[3]), 30);
    end

    // Twelve perfect hits, then a miss
    do_reset();
    bus.song_time = 16'd5000;
    for (int c = 0; c < 12; c++) set_trig(c, 16'd4995);
    pulse_done();
    wait_events(12);
`ifdef SC_COMBO_EN
    check_eq("combo_score", 64'(bus.score), 1400);
    check_eq("combo_count", 64'(bus.combo), 12);
`else
    check_eq("combo_score", 64'(bus.score), 1200);
    check_eq("combo_count", 64'(bus.combo), 0);
`endif
    bus.miss_trigger[3] = 1'b1;
    tick();
    bus.miss_trigger = '0;
    tick();
    check_eq("combo_miss_clear", 64'(bus.combo), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
